// File: rtl/alu_pkg.sv
// ============================================================================
// Module  : kgp_risc_pkg
// Brief   : Shared KGP_RISC encodings (ALU operations, operand sources,
//           shifter modes) used by the ALU and the control unit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package kgp_risc_pkg;

  localparam int XLEN       = 32;
  localparam int SHAMT_BITS = 5;

  // ALUop encodings
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_COMP = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_SLL  = 3'b100;
  localparam logic [2:0] ALU_SRL  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;
  localparam logic [2:0] ALU_SUB  = 3'b111;

  // ALUsource encodings; 2'b11 aliases SRC_B
  localparam logic [1:0] SRC_B      = 2'b00;
  localparam logic [1:0] SRC_SHAMT  = 2'b01;
  localparam logic [1:0] SRC_OFFSET = 2'b10;

  typedef enum logic [1:0] {
    SHIFT_LEFT        = 2'b00,
    SHIFT_RIGHT_LOGIC = 2'b01,
    SHIFT_RIGHT_ARITH = 2'b10
  } shift_mode_e;

endpackage : kgp_risc_pkg

`default_nettype wire

// File: rtl/alu_if.sv
// ============================================================================
// Module  : alu_if
// Brief   : Operand/operation inputs and registered result/flag outputs of
//           the execute-stage ALU.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_if #(
  parameter int WIDTH = 32
) ();

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] shamt;
  logic [WIDTH-1:0] offset;
  logic [1:0]       ALUsource;
  logic [2:0]       ALUop;

  logic             carry;
  logic             zero;
  logic             sign;
  logic [WIDTH-1:0] result;

  modport master (
    output a, b, shamt, offset, ALUsource, ALUop,
    input  carry, zero, sign, result
  );

  modport slave (
    input  a, b, shamt, offset, ALUsource, ALUop,
    output carry, zero, sign, result
  );

endinterface : alu_if

`default_nettype wire

// File: rtl/alu_shifter.sv
// ============================================================================
// Module  : alu_shifter
// Brief   : Combinational 5-stage barrel shifter (SLL/SRL/SRA) that also
//           reports the last bit shifted out.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_shifter
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH-1:0]      data,
  input  wire logic [SHAMT_BITS-1:0] amount,
  input  shift_mode_e                mode,
  output logic      [WIDTH-1:0]      shifted,
  output logic                       shift_out
);

  // Each active stage overwrites shift_out, so the final value is the last
  // bit to leave the word across all cascaded stages.
  always_comb begin
    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] probe;
    logic             out_bit;
    int               step;
    stage   = data;
    probe   = '0;
    out_bit = 1'b0;
    step    = 0;
    for (int k = 0; k < SHAMT_BITS; k++) begin
      if (amount[k]) begin
        step = 1 << k;
        case (mode)
          SHIFT_LEFT: begin
            probe   = stage >> (WIDTH - step);
            out_bit = probe[0];
            stage   = stage << step;
          end
          SHIFT_RIGHT_LOGIC: begin
            probe   = stage >> (step - 1);
            out_bit = probe[0];
            stage   = stage >> step;
          end
          SHIFT_RIGHT_ARITH: begin
            probe   = stage >> (step - 1);
            out_bit = probe[0];
            stage   = $signed(stage) >>> step;
          end
          default: begin
            stage   = stage;
            out_bit = out_bit;
          end
        endcase
      end
    end
    shifted   = stage;
    shift_out = out_bit;
  end

endmodule : alu_shifter

`default_nettype wire

// File: rtl/alu.sv
// ============================================================================
// Module  : alu
// Brief   : Registered 32-bit KGP_RISC ALU with carry/zero/sign flags.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module alu
  import kgp_risc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic clk,
  input  wire logic rst,
  alu_if.slave      bus
);

  logic [WIDTH-1:0] op2;
  logic [WIDTH-1:0] add_lhs;
  logic [WIDTH-1:0] add_rhs;
  logic             add_cin;
  logic [WIDTH:0]   sum;
  shift_mode_e      shift_mode;
  logic [WIDTH-1:0] shift_value;
  logic             shift_bit;
  logic [WIDTH-1:0] next_result;
  logic             next_carry;

  always_comb begin
    op2 = bus.b;
    case (bus.ALUsource)
      SRC_SHAMT:  op2 = bus.shamt;
      SRC_OFFSET: op2 = bus.offset;
      default:    op2 = bus.b;
    endcase
  end

  // One adder serves ADD, SUB (a + ~op2 + 1) and COMP (0 + ~op2 + 1).
  always_comb begin
    add_lhs = bus.a;
    add_rhs = op2;
    add_cin = 1'b0;
    case (bus.ALUop)
      ALU_SUB: begin
        add_rhs = ~op2;
        add_cin = 1'b1;
      end
      ALU_COMP: begin
        add_lhs = '0;
        add_rhs = ~op2;
        add_cin = 1'b1;
      end
      default: begin
        add_lhs = bus.a;
        add_rhs = op2;
        add_cin = 1'b0;
      end
    endcase
  end

  assign sum = {1'b0, add_lhs} + {1'b0, add_rhs} + {{WIDTH{1'b0}}, add_cin};

  always_comb begin
    shift_mode = SHIFT_LEFT;
    case (bus.ALUop)
      ALU_SRL: shift_mode = SHIFT_RIGHT_LOGIC;
      ALU_SRA: shift_mode = SHIFT_RIGHT_ARITH;
      default: shift_mode = SHIFT_LEFT;
    endcase
  end

  alu_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .data      (bus.a),
    .amount    (op2[SHAMT_BITS-1:0]),
    .mode      (shift_mode),
    .shifted   (shift_value),
    .shift_out (shift_bit)
  );

  always_comb begin
    next_result = '0;
    next_carry  = 1'b0;
    case (bus.ALUop)
      ALU_ADD, ALU_SUB, ALU_COMP: begin
        next_result = sum[WIDTH-1:0];
        next_carry  = sum[WIDTH];
      end
      ALU_AND: next_result = bus.a & op2;
      ALU_XOR: next_result = bus.a ^ op2;
      ALU_SLL, ALU_SRL, ALU_SRA: begin
        next_result = shift_value;
        next_carry  = shift_bit;
      end
      default: begin
        next_result = '0;
        next_carry  = 1'b0;
      end
    endcase
  end

  // zero is forced low in reset rather than derived from the cleared result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.result <= '0;
      bus.carry  <= 1'b0;
      bus.zero   <= 1'b0;
      bus.sign   <= 1'b0;
    end else begin
      bus.result <= next_result;
      bus.carry  <= next_carry;
      bus.zero   <= (next_result == '0);
      bus.sign   <= next_result[WIDTH-1];
    end
  end

endmodule : alu

`default_nettype wire

// File: tb/tb_alu.sv
// ============================================================================
// Module  : tb_alu
// Brief   : Self-checking bench for alu: directed vectors plus randomized
//           operations against a behavioural reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu;
  import kgp_risc_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] shamt;
    logic [31:0] offset;
    logic [1:0]  src;
    logic [2:0]  op;
    logic [34:0] exp;   // {carry, zero, sign, result}
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  alu_if #(.WIDTH(32)) bus ();

  alu #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [31:0] a, b, shamt, offset,
                              input logic [1:0] src, input logic [2:0] op,
                              input logic c, z, s, input logic [31:0] r,
                              input string name);
    vec_t v;
    v.a = a; v.b = b; v.shamt = shamt; v.offset = offset;
    v.src = src; v.op = op; v.exp = {c, z, s, r}; v.name = name;
    return v;
  endfunction

  // Reference: arithmetic straight from the operation definitions.
  function automatic logic [34:0] ref_model(input logic [31:0] a, b, shamt, offset,
                                            input logic [1:0] src, input logic [2:0] op);
    logic [31:0]    op2;
    logic [31:0]    res;
    logic           c;
    longint unsigned wide;
    int             sh;
    op2 = (src == 2'd1) ? shamt : (src == 2'd2) ? offset : b;
    sh  = int'(op2 % 32);
    c   = 1'b0;
    case (op)
      3'd0: begin
        wide = longint'(a) + longint'(op2);
        res  = wide[31:0];
        c    = (wide >= 64'h1_0000_0000);
      end
      3'd1: begin res = 32'd0 - op2; c = (op2 == 0); end
      3'd2: res = a & op2;
      3'd3: res = a ^ op2;
      3'd4: begin res = a << sh; c = (sh == 0) ? 1'b0 : a[32 - sh]; end
      3'd5: begin res = a >> sh; c = (sh == 0) ? 1'b0 : a[sh - 1]; end
      3'd6: begin
        res = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
        c   = (sh == 0) ? 1'b0 : a[sh - 1];
      end
      default: begin res = a - op2; c = (a >= op2); end
    endcase
    return {c, (res == 0), res[31], res};
  endfunction

  task automatic drive(input logic [31:0] a, b, shamt, offset,
                       input logic [1:0] src, input logic [2:0] op);
    bus.a = a; bus.b = b; bus.shamt = shamt; bus.offset = offset;
    bus.ALUsource = src; bus.ALUop = op;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_random();
    drive($urandom, $urandom, $urandom, $urandom,
          2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
  endtask

  task automatic test_reset();
    logic [34:0] got;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      step();
      got = {bus.carry, bus.zero, bus.sign, bus.result};
      checks++;
      if (got !== 35'd0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h expected 0", i, got);
      end
    end
    rst = 1'b0;
    drive(32, 16, 0, 0, SRC_B, ALU_ADD);
    step();
    got = {bus.carry, bus.zero, bus.sign, bus.result};
    checks++;
    if (got !== {3'b000, 32'd48}) begin
      errors++;
      $display("FAIL reset_release: got c=%0b z=%0b s=%0b r=%h expected c=0 z=0 s=0 r=00000030",
               got[34], got[33], got[32], got[31:0]);
    end
  endtask

  task automatic test_directed();
    vec_t        tbl[$];
    logic [34:0] got;
    tbl.push_back(mk(32, 0, 0, 10, SRC_OFFSET, ALU_ADD, 0, 0, 0, 32'd42, "sel_offset_add"));
    tbl.push_back(mk(32, 16, 0, 0, SRC_B, ALU_SUB, 1, 0, 0, 32'd16, "sel_b_sub"));
    tbl.push_back(mk(32, 16, 0, 0, 2'b11, ALU_ADD, 0, 0, 0, 32'd48, "sel_11_is_b"));
    tbl.push_back(mk(32'hFFFF_FFFF, 1, 0, 0, SRC_B, ALU_ADD, 1, 1, 0, 32'd0, "add_wrap"));
    tbl.push_back(mk(5, 7, 0, 0, SRC_B, ALU_SUB, 0, 0, 1, 32'hFFFF_FFFE, "sub_borrow"));
    tbl.push_back(mk(7, 7, 0, 0, SRC_B, ALU_SUB, 1, 1, 0, 32'd0, "sub_equal"));
    tbl.push_back(mk(32, 0, 2, 0, SRC_SHAMT, ALU_SLL, 0, 0, 0, 32'd128, "sll_2"));
    tbl.push_back(mk(32'h8000_0001, 0, 4, 0, SRC_SHAMT, ALU_SRA, 0, 0, 1, 32'hF800_0000, "sra_4"));
    tbl.push_back(mk(32'h8000_0001, 0, 1, 0, SRC_SHAMT, ALU_SRL, 1, 0, 0, 32'h4000_0000, "srl_1"));
    tbl.push_back(mk(32, 0, 32'h22, 0, SRC_SHAMT, ALU_SLL, 0, 0, 0, 32'd128, "shamt_upper_ignored"));
    tbl.push_back(mk(32'h8000_0000, 0, 1, 0, SRC_SHAMT, ALU_SLL, 1, 1, 0, 32'd0, "sll_out_msb"));
    tbl.push_back(mk(1, 0, 0, 0, SRC_SHAMT, ALU_SRL, 0, 0, 0, 32'd1, "srl_0"));
    tbl.push_back(mk(32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, SRC_B, ALU_AND, 0, 0, 1, 32'hF000_F000, "and"));
    tbl.push_back(mk(32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, SRC_B, ALU_XOR, 0, 0, 0, 32'h0FF0_0FF0, "xor"));
    tbl.push_back(mk(0, 16, 0, 0, SRC_B, ALU_COMP, 0, 0, 1, 32'hFFFF_FFF0, "comp_16"));
    tbl.push_back(mk(9, 0, 0, 0, SRC_B, ALU_COMP, 1, 1, 0, 32'd0, "comp_0"));
    foreach (tbl[i]) begin
      drive(tbl[i].a, tbl[i].b, tbl[i].shamt, tbl[i].offset, tbl[i].src, tbl[i].op);
      step();
      got = {bus.carry, bus.zero, bus.sign, bus.result};
      checks++;
      if (got !== tbl[i].exp) begin
        errors++;
        $display("FAIL %s: got c=%0b z=%0b s=%0b r=%h expected c=%0b z=%0b s=%0b r=%h",
                 tbl[i].name, got[34], got[33], got[32], got[31:0],
                 tbl[i].exp[34], tbl[i].exp[33], tbl[i].exp[32], tbl[i].exp[31:0]);
      end
    end
  endtask

  // Back-to-back random ops; also confirms outputs hold while inputs change mid-cycle.
  task automatic test_back_to_back();
    logic [34:0] exp;
    logic [34:0] got;
    exp = ref_model(bus.a, bus.b, bus.shamt, bus.offset, bus.ALUsource, bus.ALUop);
    step();
    for (int i = 0; i < 300; i++) begin
      got = {bus.carry, bus.zero, bus.sign, bus.result};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d]: got %h expected %h", i, got, exp);
      end
      drive_random();
      if (($urandom & 3) == 0) bus.shamt = 32'(i % 32);
      #2;
      checks++;
      if ({bus.carry, bus.zero, bus.sign, bus.result} !== exp) begin
        errors++;
        $display("FAIL hold_between_edges[%0d]: got %h expected %h",
                 i, {bus.carry, bus.zero, bus.sign, bus.result}, exp);
      end
      exp = ref_model(bus.a, bus.b, bus.shamt, bus.offset, bus.ALUsource, bus.ALUop);
      step();
    end
  endtask

  task automatic test_async_reset();
    logic [34:0] exp;
    logic [34:0] got;
    for (int i = 0; i < 4; i++) begin
      drive(32'hFFFF_0000 + 32'(i), 32'h10, 0, 0, SRC_B, ALU_ADD);
      step();
    end
    drive_random();
    #2;
    rst = 1'b1;
    #1;
    got = {bus.carry, bus.zero, bus.sign, bus.result};
    checks++;
    if (got !== 35'd0) begin
      errors++;
      $display("FAIL async_reset_clear: got %h expected 0", got);
    end
    for (int i = 0; i < 2; i++) begin
      drive_random();
      step();
      got = {bus.carry, bus.zero, bus.sign, bus.result};
      checks++;
      if (got !== 35'd0) begin
        errors++;
        $display("FAIL async_reset_hold[%0d]: got %h expected 0", i, got);
      end
    end
    rst = 1'b0;
    drive(32'h1234_5678, 32'h0000_1111, 0, 0, SRC_B, ALU_SUB);
    exp = ref_model(bus.a, bus.b, bus.shamt, bus.offset, bus.ALUsource, bus.ALUop);
    step();
    got = {bus.carry, bus.zero, bus.sign, bus.result};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL async_reset_release: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, SRC_B, ALU_ADD);
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu

`default_nettype wire

// File: doc/alu.md
# alu

Registered 32-bit integer ALU for the KGP_RISC datapath, sitting in the execute stage between the register-file/immediate muxing and the writeback/branch logic. It selects a second operand from `b`, `shamt` or `offset`, performs one of eight arithmetic, logic or shift operations, and registers the result together with carry, zero and sign flags. The flags feed branch-condition evaluation.

## Interface
Parameters:
- `WIDTH`, 32, datapath width; only 32 is required to be supported.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous and active-high.
- `a`  input  32  first operand (rs).
- `b`  input  32  register second operand (rt).
- `shamt`  input  32  shift amount; only bits [4:0] are used.
- `offset`  input  32  sign-extended immediate/offset.
- `ALUsource`  input  2  second-operand select.
- `ALUop`  input  3  operation select.
- `carry`  output  1  carry/borrow/shift-out flag.
- `zero`  output  1  high when `result` == 0.
- `sign`  output  1  equals `result[31]`.
- `result`  output  32  operation result.

## Operation
Operand select (`op2`):
- 00 selects `b`; 01 selects `shamt`; 10 selects `offset`; 11 selects `b`.

Shift amount is always `op2[4:0]`. Upper bits are ignored.

ALUop:
- 000 ADD: `a + op2`. Carry is the unsigned carry-out of bit 31.
- 001 COMP: `~op2 + 1` (two's complement). Carry is the carry-out of that increment, so it is 1 only when `op2 == 0`.
- 010 AND: `a & op2`. Carry = 0.
- 011 XOR: `a ^ op2`. Carry = 0.
- 100 SLL: `a << sh`. Carry is the last bit shifted out, `a[32-sh]`; it is 0 when `sh == 0`.
- 101 SRL: `a >> sh` with zero fill. Carry is `a[sh-1]`; it is 0 when `sh == 0`.
- 110 SRA: `a >>> sh` with sign fill. Carry is `a[sh-1]`; it is 0 when `sh == 0`.
- 111 SUB: `a - op2`, computed as `a + ~op2 + 1`. Carry is the carry-out, so it is 1 when `a >= op2` unsigned (no borrow).

Flags:
- `zero` is `(next_result == 0)` and `sign` is `next_result[31]`. Both are computed from the same value that is registered into `result`.
- Arithmetic is modulo 2^32. No overflow flag is produced.

## Timing
- Combinational compute, registered outputs.
- Latency is 1 cycle: inputs sampled at rising edge N appear on outputs after edge N.
- No enable and no handshake. A new operation can be issued every cycle, and the outputs update every edge.
- Reset: asserting `rst` immediately (asynchronously) forces `result = 0`, `carry = 0`, `zero = 0`, `sign = 0`.
  - `zero` is deliberately 0 during reset, not derived from `result`.
- Outputs remain at these values while `rst` is high.
- On the first rising edge after `rst` deasserts, the current inputs are captured.
- Reset asserted mid-operation discards the in-flight result. No partial state survives.
- Inputs that change between edges have no effect until the next edge.

## Structure
- Shared package `kgp_risc_pkg`:
  - ALUop encodings: `ALU_ADD`, `ALU_COMP`, `ALU_AND`, `ALU_XOR`, `ALU_SLL`, `ALU_SRL`, `ALU_SRA`, `ALU_SUB`.
  - ALUsource encodings: `SRC_B`, `SRC_SHAMT`, `SRC_OFFSET`.
  - These are also used by the control unit.
- Sub-module `alu_shifter`: combinational 5-stage barrel shifter with inputs data, amount and mode (SLL/SRL/SRA), and outputs shifted value and shift-out bit.
- The adder/subtractor and output registers stay in `alu`.

## Test plan
- Reset: hold `rst` = 1 with arbitrary inputs -> all outputs 0. Release with `a` = 32, `b` = 16, ALUsource = 00, ALUop = 000 -> after next edge `result` = 48, `carry` = 0, `zero` = 0, `sign` = 0.
- Operand select: `a` = 32, `offset` = 10, ALUsource = 10, ALUop = 000 -> `result` = 42. Then ALUsource = 00, ALUop = 111 with `b` = 16 -> `result` = 16, `carry` = 1.
- Wrap/zero: `a` = 0xFFFFFFFF, `b` = 1, ADD -> `result` = 0, `carry` = 1, `zero` = 1. SUB with `a` = 5, `b` = 7 -> `result` = 0xFFFFFFFE, `carry` = 0, `sign` = 1.
- Shifts: `a` = 32, ALUsource = 01, `shamt` = 2, SLL -> 128, `carry` = 0. `a` = 0x80000001 with SRA `shamt` = 4 -> 0xF8000000, `carry` = 0. SRL `shamt` = 1 -> 0x40000000, `carry` = 1. `shamt` = 0x22 uses amount 2.
- Logic/comp: `a` = 0xF0F0F0F0, `b` = 0xFF00FF00 -> AND gives 0xF000F000 and XOR gives 0x0FF00FF0. COMP with `b` = 16 -> 0xFFFFFFF0, `sign` = 1, `carry` = 0. COMP with `b` = 0 -> 0, `zero` = 1, `carry` = 1.
- Async reset mid-stream: change inputs every cycle, then assert `rst` between edges -> outputs clear before the next edge and stay 0 until release.
